// File: rtl/timer_pkg.sv
// Shared types and constants for the timer run-control slice.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } timer_state_e;

  localparam int                     TIMER_CNT_W        = 4;
  localparam logic [TIMER_CNT_W-1:0] TIMER_DIV_TERMINAL = 4'd9;

endpackage

// File: rtl/timer_btn_cond.sv
// Raw push-button conditioning: 2-flop synchronizer, debounce counter and
// press edge detector producing a one-cycle pulse on press only.
module timer_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic sys_clk,
  input  logic int_reset_b,
  input  logic btn,
  output logic press
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync_p0;
  logic       sync_p1;
  logic       level_p2;
  logic       level_p3;
  logic [7:0] db_cnt;

  always_ff @(posedge sys_clk) begin
    if (!int_reset_b) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      level_p2 <= 1'b0;
      level_p3 <= 1'b0;
      db_cnt   <= '0;
    end else begin
      // synchronizer
      sync_p0  <= btn;
      sync_p1  <= sync_p0;
      // debounce: any agreeing sample restarts the stability count
      if (sync_p1 == level_p2) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level_p2 <= sync_p1;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
      // edge detect
      level_p3 <= level_p2;
    end
  end

  assign press = level_p2 & ~level_p3;

endmodule

// File: rtl/timer_ctrl.sv
// Run-control sequencer: conditions three buttons, runs IDLE/RUN/PAUSED and
// drives the prescaler count, clear/pause controls and the lap freeze flag.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int                     DEBOUNCE_CYCLES = 4,
  parameter logic [TIMER_CNT_W-1:0] DIV_TERMINAL    = TIMER_DIV_TERMINAL
) (
  input  logic                   sys_clk,
  input  logic                   int_reset_b,
  input  logic                   btn_start_stop,
  input  logic                   btn_clear,
  input  logic                   btn_lap,
  output logic [TIMER_CNT_W-1:0] timer_clk_count,
  output logic                   timer_clear,
  output logic                   timer_pause,
  output logic                   lap_hold,
  output logic [1:0]             timer_state
);

  function automatic logic [TIMER_CNT_W-1:0] cnt_inc(input logic [TIMER_CNT_W-1:0] cnt);
    return (cnt == DIV_TERMINAL) ? '0 : cnt + TIMER_CNT_W'(1);
  endfunction

  logic                   ss_pulse;
  logic                   clr_pulse;
  logic                   lap_pulse;
  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [TIMER_CNT_W-1:0] cnt_d;
  logic                   lap_d;

  timer_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
    .sys_clk    (sys_clk),
    .int_reset_b(int_reset_b),
    .btn        (btn_start_stop),
    .press      (ss_pulse)
  );

  timer_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
    .sys_clk    (sys_clk),
    .int_reset_b(int_reset_b),
    .btn        (btn_clear),
    .press      (clr_pulse)
  );

  timer_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
    .sys_clk    (sys_clk),
    .int_reset_b(int_reset_b),
    .btn        (btn_lap),
    .press      (lap_pulse)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ss_pulse) state_d = ST_RUN;
      ST_RUN:    if (ss_pulse) state_d = ST_PAUSED;
      ST_PAUSED: if (ss_pulse) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
    if (clr_pulse) state_d = ST_IDLE;
  end

  // Count advances only while staying in RUN, so entering or leaving RUN holds it.
  always_comb begin
    cnt_d = timer_clk_count;
    if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN && state_d == ST_RUN) begin
      cnt_d = cnt_inc(timer_clk_count);
    end
  end

  // Lap reacts to the state before any same-cycle start/stop transition.
  always_comb begin
    lap_d = lap_hold;
    if (state_d == ST_IDLE) begin
      lap_d = 1'b0;
    end else if (lap_pulse) begin
      if (state_q == ST_RUN) begin
        lap_d = ~lap_hold;
      end else if (state_q == ST_PAUSED) begin
        lap_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!int_reset_b) begin
      state_q         <= ST_IDLE;
      timer_clk_count <= '0;
      lap_hold        <= 1'b0;
      timer_clear     <= 1'b1;
      timer_pause     <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_clk_count <= cnt_d;
      lap_hold        <= lap_d;
      timer_clear     <= (state_d == ST_IDLE);
      timer_pause     <= (state_d == ST_PAUSED);
    end
  end

  assign timer_state = state_q;

endmodule
